// File: rtl/spi_controller_if.sv
// Request-side bundle for spi_controller: valid/ready write requests plus status.
interface spi_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, busy, done
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 write-only frame generator: {1'b1, addr[6:0], data[7:0]} MSB first,
// with programmable sclk half-period and chip-select setup/hold/idle times.
module spi_controller #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_controller_if.slave req,
    output logic            ncs,
    output logic            sclk,
    output logic            copi
);
    localparam int unsigned MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int unsigned MAX_PH = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    // Phase counter counts down from (length-1) to 0.
    localparam int unsigned PW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

    localparam logic [PW-1:0] DIV_LD   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] SETUP_LD = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] HOLD_LD  = PW'(CS_HOLD - 1);
    localparam logic [PW-1:0] IDLE_LD  = PW'((CS_IDLE > 0) ? (CS_IDLE - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   sr_q, sr_d;
    logic          ncs_q, ncs_d;
    logic          sclk_q, sclk_d;
    logic          copi_q, copi_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Next values of every output are decided here so all pins leave a flop.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        case (state_q)
            S_IDLE: begin
                if (req.req_valid && ready_q) begin
                    state_d = S_SETUP;
                    ph_d    = SETUP_LD;
                    bit_d   = 4'd15;
                    sr_d    = {1'b1, req.req_addr, req.req_data};
                    ncs_d   = 1'b0;
                    copi_d  = 1'b1;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (ph_q == '0) begin
                    state_d = S_LOW;
                    ph_d    = DIV_LD;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            S_LOW: begin
                if (ph_q == '0) begin
                    state_d = S_HIGH;
                    ph_d    = DIV_LD;
                    sclk_d  = 1'b1;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            S_HIGH: begin
                if (ph_q == '0) begin
                    sclk_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        state_d = S_HOLD;
                        ph_d    = HOLD_LD;
                        copi_d  = 1'b0;
                    end else begin
                        // copi advances on the falling edge, stable at the next rise
                        state_d = S_LOW;
                        ph_d    = DIV_LD;
                        bit_d   = bit_q - 4'd1;
                        sr_d    = {sr_q[14:0], 1'b0};
                        copi_d  = sr_q[14];
                    end
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (ph_q == '0) begin
                    ncs_d  = 1'b1;
                    done_d = 1'b1;
                    if (CS_IDLE == 0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        ph_d    = IDLE_LD;
                    end
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            S_GAP: begin
                if (ph_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ncs           = ncs_q;
    assign sclk          = sclk_q;
    assign copi          = copi_q;
    assign req.done      = done_q;
    assign req.busy      = busy_q;
    assign req.req_ready = ready_q;
endmodule
